// File: rtl/gpio_cp_pkg.sv
// Shared GPIO command-processor definitions: edge polarity codes, event layout
// and the edge-enable decode used by the capture block.
package gpio_cp_pkg;

    localparam int GPIO_TS_W = 32;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    typedef struct packed {
        logic                 edgeDir;
        logic [GPIO_TS_W-1:0] ts;
    } gpio_event_t;

    // newLevel is the level being adopted, so it also encodes the edge direction.
    function automatic logic edgeWanted(input logic newLevel, input logic cfgRise,
                                        input logic cfgFall);
        return (newLevel == EDGE_RISE) ? cfgRise : cfgFall;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Count-based circular event FIFO with wrapping pointers; the head is presented
// combinationally from storage and reads as zero when empty.
module event_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enq_EN,
    input  logic [WIDTH-1:0] enq_D,
    input  logic             deq_EN,
    output logic [WIDTH-1:0] deq_D,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             doEnq;
    logic             doDeq;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign deq_D = empty ? '0 : mem[rdPtr];

    // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
    assign doDeq = deq_EN && !empty;
    assign doEnq = enq_EN && (!full || doDeq);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doEnq) wrPtr <= wrPtr + 1'b1;
            if (doDeq) rdPtr <= rdPtr + 1'b1;
            case ({doEnq, doDeq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (doEnq) mem[wrPtr] <= enq_D;
    end

    popWhenEmpty: assert property (@(posedge CLK) disable iff (!RST_N) deq_EN |-> !empty);

endmodule

// File: rtl/gpio_edge_capture.sv
// Deglitches the synchronised GPIO level, timestamps enabled edges with a
// free-running counter and queues {edge, ts} events for the command processor.
module gpio_edge_capture
    import gpio_cp_pkg::*;
#(
    parameter logic init   = 1'b0,
    parameter int   TS_W   = GPIO_TS_W,
    parameter int   FILT_W = 4,
    parameter int   DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              D_IN,
    input  logic [FILT_W-1:0] cfg_filt,
    input  logic              cfg_rise,
    input  logic              cfg_fall,
    output logic              level,
    output logic              deq_RDY,
    input  logic              deq_EN,
    output logic              deq_edge,
    output logic [TS_W-1:0]   deq_ts,
    output logic              ovf,
    input  logic              ovf_clr
);

    logic [FILT_W-1:0] filtCnt;
    logic [TS_W-1:0]   ts;
    logic              edgeNow;
    logic              enqReq;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [TS_W:0]     fifoHead;

    // >= rather than == so lowering cfg_filt mid-count releases the edge at once.
    assign edgeNow = (D_IN != level) && (filtCnt >= cfg_filt);
    assign enqReq  = edgeNow && edgeWanted(D_IN, cfg_rise, cfg_fall);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level   <= init;
            filtCnt <= '0;
        end else if (D_IN == level) begin
            filtCnt <= '0;
        end else if (edgeNow) begin
            level   <= D_IN;
            filtCnt <= '0;
        end else if (filtCnt != '1) begin
            filtCnt <= filtCnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ts <= '0;
        else        ts <= ts + 1'b1;
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                           ovf <= 1'b0;
        else if (enqReq && fifoFull && !(deq_EN && !fifoEmpty)) ovf <= 1'b1;
        else if (ovf_clr)                                     ovf <= 1'b0;
    end

    event_fifo #(
        .WIDTH(TS_W + 1),
        .DEPTH(DEPTH)
    ) uFifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .enq_EN(enqReq),
        .enq_D ({D_IN, ts}),
        .deq_EN(deq_EN),
        .deq_D (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign deq_RDY  = !fifoEmpty;
    assign deq_edge = fifoHead[TS_W];
    assign deq_ts   = fifoHead[TS_W-1:0];

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Directed and randomized bench for gpio_edge_capture against a queue-based event model.
module tb_gpio_edge_capture;

    localparam int TS_W   = 4;
    localparam int FILT_W = 4;
    localparam int DEPTH  = 4;
    localparam int TS_MOD = 1 << TS_W;

    logic              CLK      = 1'b0;
    logic              RST_N    = 1'b0;
    logic              D_IN     = 1'b0;
    logic [FILT_W-1:0] cfg_filt = '0;
    logic              cfg_rise = 1'b1;
    logic              cfg_fall = 1'b1;
    logic              deq_EN   = 1'b0;
    logic              ovf_clr  = 1'b0;
    logic              level;
    logic              deq_RDY;
    logic              deq_edge;
    logic [TS_W-1:0]   deq_ts;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: run length of disagreeing samples, cycle count since reset, event queue.
    bit              mLevel;
    int              mRun;
    int              mTs;
    bit              mOvf;
    logic [TS_W:0]   mQ[$];

    gpio_edge_capture #(
        .init  (1'b0),
        .TS_W  (TS_W),
        .FILT_W(FILT_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .D_IN    (D_IN),
        .cfg_filt(cfg_filt),
        .cfg_rise(cfg_rise),
        .cfg_fall(cfg_fall),
        .level   (level),
        .deq_RDY (deq_RDY),
        .deq_EN  (deq_EN),
        .deq_edge(deq_edge),
        .deq_ts  (deq_ts),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 CLK = ~CLK;

    task automatic modelReset();
        mLevel = 1'b0;
        mRun   = 0;
        mTs    = 0;
        mOvf   = 1'b0;
        mQ.delete();
    endtask

    // Advance the model by one active clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit fire;
        bit wasFull;
        bit popNow;
        fire    = 1'b0;
        wasFull = (mQ.size() == DEPTH);
        popNow  = deq_EN;
        if (D_IN != mLevel) begin
            mRun++;
            if (mRun >= int'(cfg_filt) + 1) begin
                fire   = 1'b1;
                mLevel = D_IN;
                mRun   = 0;
            end
        end else begin
            mRun = 0;
        end
        if (popNow) void'(mQ.pop_front());
        if (ovf_clr) mOvf = 1'b0;
        if (fire && ((mLevel && cfg_rise) || (!mLevel && cfg_fall))) begin
            if (wasFull && !popNow) mOvf = 1'b1;
            else mQ.push_back({mLevel, TS_W'(mTs)});
        end
        mTs = (mTs + 1) % TS_MOD;
    endtask

    task automatic cycle(input logic d, input logic pop, input logic clr);
        D_IN    = d;
        deq_EN  = pop && (mQ.size() != 0);
        ovf_clr = clr;
        modelEdge();
        @(posedge CLK);
        #1;
        deq_EN  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic doReset();
        RST_N   = 1'b0;
        deq_EN  = 1'b0;
        ovf_clr = 1'b0;
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        D_IN = 1'b1;
        RST_N = 1'b0;
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (level !== 1'b0)    begin errors++; $display("FAIL rst_level got=%0b exp=0", level); end
        checks++; if (deq_RDY !== 1'b0)  begin errors++; $display("FAIL rst_rdy got=%0b exp=0", deq_RDY); end
        checks++; if (deq_edge !== 1'b0) begin errors++; $display("FAIL rst_edge got=%0b exp=0", deq_edge); end
        checks++; if (deq_ts !== '0)     begin errors++; $display("FAIL rst_ts got=%0d exp=0", deq_ts); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
        D_IN = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic test_filter_rise();
        int t0;
        doReset();
        cfg_filt = 4'd3; cfg_rise = 1'b1; cfg_fall = 1'b1;
        t0 = mTs;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++; if (level !== 1'b0)   begin errors++; $display("FAIL filt_hold_level i=%0d got=%0b exp=0", i, level); end
            checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL filt_hold_rdy i=%0d got=%0b exp=0", i, deq_RDY); end
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (level !== 1'b1)    begin errors++; $display("FAIL filt_rise_level got=%0b exp=1", level); end
        checks++; if (deq_RDY !== 1'b1)  begin errors++; $display("FAIL filt_rise_rdy got=%0b exp=1", deq_RDY); end
        checks++; if (deq_edge !== 1'b1) begin errors++; $display("FAIL filt_rise_edge got=%0b exp=1", deq_edge); end
        checks++; if (deq_ts !== TS_W'((t0 + 3) % TS_MOD))
            begin errors++; $display("FAIL filt_rise_ts got=%0d exp=%0d", deq_ts, (t0 + 3) % TS_MOD); end
    endtask

    task automatic test_glitch();
        doReset();
        cfg_filt = 4'd3;
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        checks++; if (level !== 1'b0)   begin errors++; $display("FAIL glitch_level got=%0b exp=0", level); end
        checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL glitch_rdy got=%0b exp=0", deq_RDY); end
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        checks++; if (level !== 1'b0)   begin errors++; $display("FAIL glitch_cnt_cleared got=%0b exp=0", level); end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (level !== 1'b1)   begin errors++; $display("FAIL glitch_then_rise got=%0b exp=1", level); end
    endtask

    task automatic test_rise_only();
        int t0;
        doReset();
        cfg_filt = 4'd0; cfg_rise = 1'b1; cfg_fall = 1'b0;
        t0 = mTs;
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        checks++; if (deq_edge !== 1'b1 || deq_ts !== TS_W'(t0 % TS_MOD))
            begin errors++; $display("FAIL rise_only_first got=%0b/%0d exp=1/%0d", deq_edge, deq_ts, t0 % TS_MOD); end
        cycle(1'b1, 1'b1, 1'b0);
        checks++; if (deq_edge !== 1'b1 || deq_ts !== TS_W'((t0 + 4) % TS_MOD))
            begin errors++; $display("FAIL rise_only_second got=%0b/%0d exp=1/%0d", deq_edge, deq_ts, (t0 + 4) % TS_MOD); end
        cycle(1'b1, 1'b1, 1'b0);
        checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL rise_only_count got=%0b exp=0", deq_RDY); end
        cfg_fall = 1'b1;
    endtask

    task automatic test_overflow();
        int t0;
        logic [TS_W:0] expEv [4];
        doReset();
        cfg_filt = 4'd0; cfg_rise = 1'b1; cfg_fall = 1'b1;
        t0 = mTs;
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
        cycle(1'b0, 1'b1, 1'b0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_full_pop_keep got=%0b exp=1", ovf); end
        cycle(1'b0, 1'b0, 1'b1);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%0b exp=0", ovf); end
        expEv[0] = {1'b0, TS_W'((t0 + 1) % TS_MOD)};
        expEv[1] = {1'b1, TS_W'((t0 + 2) % TS_MOD)};
        expEv[2] = {1'b0, TS_W'((t0 + 3) % TS_MOD)};
        expEv[3] = {1'b0, TS_W'((t0 + 5) % TS_MOD)};
        for (int i = 0; i < 4; i++) begin
            checks++; if ({deq_edge, deq_ts} !== expEv[i])
                begin errors++; $display("FAIL ovf_order i=%0d got=%0h exp=%0h", i, {deq_edge, deq_ts}, expEv[i]); end
            cycle(1'b0, 1'b1, 1'b0);
        end
        checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL ovf_drain got=%0b exp=0", deq_RDY); end
    endtask

    task automatic test_ts_wrap();
        doReset();
        cfg_filt = 4'd0; cfg_rise = 1'b1; cfg_fall = 1'b1;
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (deq_ts !== TS_W'(14)) begin errors++; $display("FAIL wrap_first got=%0d exp=14", deq_ts); end
        cycle(1'b0, 1'b1, 1'b0);
        checks++; if (deq_ts !== TS_W'(2))  begin errors++; $display("FAIL wrap_second got=%0d exp=2", deq_ts); end
        cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        doReset();
        cfg_filt = 4'd0;
        cycle(1'b1, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
        cfg_filt = 4'd5;
        cycle(1'b0, 1'b0, 1'b0); cycle(1'b0, 1'b0, 1'b0);
        RST_N = 1'b0;
        #1;
        checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL arst_rdy got=%0b exp=0", deq_RDY); end
        checks++; if (level !== 1'b0)   begin errors++; $display("FAIL arst_level got=%0b exp=0", level); end
        checks++; if (deq_ts !== '0)    begin errors++; $display("FAIL arst_ts got=%0d exp=0", deq_ts); end
        D_IN = 1'b0;
        doReset();
        repeat (6) cycle(1'b0, 1'b0, 1'b0);
        checks++; if (deq_RDY !== 1'b0) begin errors++; $display("FAIL arst_no_event got=%0b exp=0", deq_RDY); end
        cfg_filt = 4'd0;
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (deq_ts !== TS_W'(6)) begin errors++; $display("FAIL arst_ts_restart got=%0d exp=6", deq_ts); end
        cycle(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic d;
        logic [TS_W:0] expHead;
        D_IN = 1'b1;
        doReset();
        d = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) cfg_filt = FILT_W'($urandom_range(0, 3));
            if (i % 40 == 0) begin
                cfg_rise = 1'($urandom_range(0, 1));
                cfg_fall = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) d = ~d;
            cycle(d, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
            expHead = (mQ.size() != 0) ? mQ[0] : '0;
            checks++; if (level !== mLevel)
                begin errors++; $display("FAIL rnd_level cyc=%0d got=%0b exp=%0b", i, level, mLevel); end
            checks++; if (deq_RDY !== (mQ.size() != 0))
                begin errors++; $display("FAIL rnd_rdy cyc=%0d got=%0b exp=%0b", i, deq_RDY, mQ.size() != 0); end
            checks++; if ({deq_edge, deq_ts} !== expHead)
                begin errors++; $display("FAIL rnd_head cyc=%0d got=%0h exp=%0h", i, {deq_edge, deq_ts}, expHead); end
            checks++; if (ovf !== mOvf)
                begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", i, ovf, mOvf); end
        end
    endtask

    initial begin
        test_reset();
        test_filter_rise();
        test_glitch();
        test_rise_only();
        test_overflow();
        test_ts_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
